uart_cmd_decoder: RTL

Parametrised UART command decoder between the UART receiver and the control datapath (stopwatch/watch buttons and mode switches). Buffers received bytes in a small FIFO. Decodes single-character button commands into stretched pulses, digit characters into toggles, and two-byte `S<d>`/`C<d>` commands into explicit set/clear of switch channels. Reports malformed input and FIFO overflow.

---
 rtl/uart_cmd_decoder.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART command decoder: byte FIFO, command FSM, button pulses, switch levels
//
// Buffers received UART bytes in a small FIFO and decodes them one at a time:
//   - button characters (BTN_CHARS) load a per-channel pulse counter,
//   - digits '0'..'0'+NUM_SW-1 toggle a switch channel,
//   - 'S'<d> / 'C'<d> set / clear a switch channel explicitly,
//   - CR / LF are ignored, anything else is rejected (cmd_err).
// Optional echo path under macro UART_CMD_ECHO_EN (tx_data/tx_start/tx_busy, ECHO state).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   rx_data       received byte, valid with rx_done
//   rx_done       one-cycle strobe, byte available
//   btn_pulse     stretched button pulses (PULSE_LEN cycles), registered
//   sw_state      switch levels, registered
//   cmd_err       one-cycle pulse on a rejected byte
//   fifo_ovf      one-cycle pulse on a byte dropped because the FIFO was full
//   err_cnt       saturating count of cmd_err + fifo_ovf events
//   tx_data       (UART_CMD_ECHO_EN) echo byte, '?' for a rejected byte
//   tx_start      (UART_CMD_ECHO_EN) one-cycle transmit request
//   tx_busy       (UART_CMD_ECHO_EN) transmitter busy
module uart_cmd_decoder #(
  parameter int                   NUM_BTN    = 4,
  parameter logic [8*NUM_BTN-1:0] BTN_CHARS  = 32'h64_75_6C_72,
  parameter int                   NUM_SW     = 3,
  parameter logic [NUM_SW-1:0]    SW_RESET   = '0,
  parameter int                   PULSE_LEN  = 1,
  parameter int                   FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_done,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_SW-1:0]  sw_state,
  output logic               cmd_err,
  output logic               fifo_ovf,
  output logic [7:0]         err_cnt
`ifdef UART_CMD_ECHO_EN
  ,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ARG    = 2'd2
`ifdef UART_CMD_ECHO_EN
    ,
    S_ECHO   = 2'd3
`endif
  } state_t;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_empty, fifo_full, push, pop;

  // FSM / decode
  state_t             state_q, state_d;
  logic [7:0]         cur_byte_q, cur_byte_d;
  logic               arg_pending_q, arg_pending_d;
  logic               set_flag_q, set_flag_d;
  logic [NUM_SW-1:0]  sw_state_q, sw_state_d;
  logic               cmd_err_q, cmd_err_d;
  logic [NUM_BTN-1:0] btn_load;
  logic [NUM_BTN-1:0] btn_hit;
  logic [NUM_SW-1:0]  sw_hit;
  logic               is_prefix, is_eol;

  // Button pulses and error counting
  logic [7:0]         pulse_cnt_q [NUM_BTN];
  logic [7:0]         pulse_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] btn_pulse_q, btn_pulse_d;
  logic               fifo_ovf_q, fifo_ovf_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic [8:0]         err_sum;

`ifdef UART_CMD_ECHO_EN
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
`endif

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

  // Classify the byte under decode. Scanning buttons from the top down and
  // overwriting leaves the lowest matching index as the single hit.
  always_comb begin
    btn_hit = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (cur_byte_q == BTN_CHARS[8*i +: 8]) begin
        btn_hit    = '0;
        btn_hit[i] = 1'b1;
      end
    end
    sw_hit = '0;
    for (int k = 0; k < NUM_SW; k++) begin
      sw_hit[k] = (cur_byte_q == 8'(8'h30 + k));
    end
    is_prefix = (cur_byte_q == 8'h53) || (cur_byte_q == 8'h43);
    is_eol    = (cur_byte_q == 8'h0D) || (cur_byte_q == 8'h0A);
  end

  always_comb begin
    state_d       = state_q;
    cur_byte_d    = cur_byte_q;
    arg_pending_d = arg_pending_q;
    set_flag_d    = set_flag_q;
    sw_state_d    = sw_state_q;
    cmd_err_d     = 1'b0;
    btn_load      = '0;
    pop           = 1'b0;
`ifdef UART_CMD_ECHO_EN
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_ARG: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          cur_byte_d = mem_q[rd_ptr_q];
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (arg_pending_q) begin
          // Second byte of S<d>/C<d>: only a valid digit is accepted.
          arg_pending_d = 1'b0;
          if (|sw_hit) begin
            sw_state_d = set_flag_q ? (sw_state_q | sw_hit) : (sw_state_q & ~sw_hit);
          end else begin
            cmd_err_d = 1'b1;
          end
        end else if (|btn_hit) begin
          btn_load = btn_hit;
        end else if (|sw_hit) begin
          sw_state_d = sw_state_q ^ sw_hit;
        end else if (is_prefix) begin
          arg_pending_d = 1'b1;
          set_flag_d    = (cur_byte_q == 8'h53);
        end else if (!is_eol) begin
          cmd_err_d = 1'b1;
        end
`ifdef UART_CMD_ECHO_EN
        tx_data_d = cmd_err_d ? 8'h3F : cur_byte_q;
        state_d   = S_ECHO;
`else
        state_d   = arg_pending_d ? S_ARG : S_IDLE;
`endif
      end
`ifdef UART_CMD_ECHO_EN
      S_ECHO: begin
        // arg_pending_q still tells whether the echoed byte was a prefix.
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = arg_pending_q ? S_ARG : S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
    push       = rx_done && (!fifo_full || pop);
    fifo_ovf_d = rx_done && fifo_full && !pop;
    mem_d      = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = rx_data;
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // A retrigger reloads rather than extends the pulse.
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_load[i]) begin
        pulse_cnt_d[i] = 8'(PULSE_LEN);
      end else if (pulse_cnt_q[i] != 8'd0) begin
        pulse_cnt_d[i] = pulse_cnt_q[i] - 8'd1;
      end else begin
        pulse_cnt_d[i] = 8'd0;
      end
      btn_pulse_d[i] = (pulse_cnt_d[i] != 8'd0);
    end

    err_sum   = {1'b0, err_cnt_q} + 9'(cmd_err_d) + 9'(fifo_ovf_d);
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q         <= '{default: 8'h00};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      cur_byte_q    <= 8'h00;
      arg_pending_q <= 1'b0;
      set_flag_q    <= 1'b0;
      sw_state_q    <= SW_RESET;
      cmd_err_q     <= 1'b0;
      fifo_ovf_q    <= 1'b0;
      err_cnt_q     <= 8'h00;
      pulse_cnt_q   <= '{default: 8'h00};
      btn_pulse_q   <= '0;
`ifdef UART_CMD_ECHO_EN
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
`endif
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      cur_byte_q    <= cur_byte_d;
      arg_pending_q <= arg_pending_d;
      set_flag_q    <= set_flag_d;
      sw_state_q    <= sw_state_d;
      cmd_err_q     <= cmd_err_d;
      fifo_ovf_q    <= fifo_ovf_d;
      err_cnt_q     <= err_cnt_d;
      pulse_cnt_q   <= pulse_cnt_d;
      btn_pulse_q   <= btn_pulse_d;
`ifdef UART_CMD_ECHO_EN
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
`endif
    end
  end

  assign btn_pulse = btn_pulse_q;
  assign sw_state  = sw_state_q;
  assign cmd_err   = cmd_err_q;
  assign fifo_ovf  = fifo_ovf_q;
  assign err_cnt   = err_cnt_q;
`ifdef UART_CMD_ECHO_EN
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
`endif

endmodule
